// File: rtl/extremum_tracker_pkg.sv
// Shared types and constants for the multi-lane extremum tracker.
// Lane-level reset constants live in extremum_lane because they depend on the lane width.
package extremum_tracker_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned LOG_W   = 5;
  localparam int unsigned SHIFT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    COMMIT  = 2'b10
  } state_e;

  // Lane width derived from the packed sample width and the lane count
  function automatic int unsigned lane_width(input int unsigned data_w, input int unsigned lanes);
    return data_w / lanes;
  endfunction

endpackage

// File: rtl/extremum_tracker_if.sv
// AXI-Stream sample bus feeding the extremum tracker.
interface extremum_tracker_if #(
  parameter int unsigned DATA_W = 32
);

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/extremum_tracker_lane.sv
// One signed lane: running min/max over a window and the commit-time
// center/threshold arithmetic, with registered results.
module extremum_lane
  import extremum_tracker_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_en_i,
  input  logic                sample_first_i,
  input  logic                commit_i,
  input  logic [SHIFT_W-1:0]  shift_i,
  input  logic signed [W-1:0] sample_i,
  output logic signed [W-1:0] lower_o,
  output logic signed [W-1:0] upper_o,
  output logic signed [W-1:0] center_o
);

  localparam logic [W-1:0] LANE_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LANE_MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] min_q, min_d, max_q, max_d;
  logic signed [W-1:0] lower_q, lower_d, upper_q, upper_d, center_q, center_d;
  logic signed [W:0]   min_x, max_x, sum_x, center_x, d_lo_x, d_hi_x, lo_x, hi_x;

  // Running extrema; the first sample of a window seeds both
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (sample_en_i) begin
      if (sample_first_i) begin
        min_d = sample_i;
        max_d = sample_i;
      end else begin
        if (sample_i < min_q) min_d = sample_i;
        if (sample_i > max_q) max_d = sample_i;
      end
    end
  end

  // One extra bit keeps the sum and the extremum-to-center distances exact
  always_comb begin
    min_x    = {min_q[W-1], min_q};
    max_x    = {max_q[W-1], max_q};
    sum_x    = max_x + min_x;
    center_x = sum_x >>> 1;
    d_lo_x   = min_x - center_x;
    d_hi_x   = max_x - center_x;
    lo_x     = center_x + (d_lo_x >>> shift_i);
    hi_x     = center_x + (d_hi_x >>> shift_i);

    lower_d  = lower_q;
    upper_d  = upper_q;
    center_d = center_q;
    if (commit_i) begin
      lower_d  = W'(lo_x);
      upper_d  = W'(hi_x);
      center_d = W'(center_x);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      min_q    <= '0;
      max_q    <= '0;
      lower_q  <= LANE_MAX_POS;
      upper_q  <= LANE_MAX_NEG;
      center_q <= '0;
    end else begin
      min_q    <= min_d;
      max_q    <= max_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
      center_q <= center_d;
    end
  end

  assign lower_o  = lower_q;
  assign upper_o  = upper_q;
  assign center_o = center_q;

endmodule

// File: rtl/extremum_tracker.sv
// Multi-lane windowed min/max tracker publishing per-lane center and contracted
// thresholds once per window of 2^EF_log_count accepted samples.
module extremum_tracker
  import extremum_tracker_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CHANNEL_COUNT    = 2
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic                        EF_enable,
  input  logic [LOG_W-1:0]            EF_log_count,
  input  logic [SHIFT_W-1:0]          EF_shift,
  output logic [AXIS_TDATA_WIDTH-1:0] EF_lower_treshold,
  output logic [AXIS_TDATA_WIDTH-1:0] EF_upper_treshold,
  output logic [AXIS_TDATA_WIDTH-1:0] EF_center,
  output logic                        EF_update,
  extremum_tracker_if.slave           S_AXIS
);

  localparam int unsigned W = lane_width(AXIS_TDATA_WIDTH, CHANNEL_COUNT);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LOG_W-1:0]     log_q, log_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 update_q, update_d;

  logic last_c, cfg_load_c, sample_en_c, sample_first_c, commit_c;

  assign S_AXIS.tready = 1'b1;
  assign last_c = (cnt_q == ((CNT_W'(1) << log_q) - CNT_W'(1)));

  always_ff @(posedge SYS_aclk) begin
    if (!SYS_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Abort in MEASURE has priority over the window-closing sample
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (EF_enable) state_d = MEASURE;
      MEASURE: begin
        if (!EF_enable)                      state_d = IDLE;
        else if (S_AXIS.tvalid && last_c)    state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_load_c     = 1'b0;
    sample_en_c    = 1'b0;
    sample_first_c = 1'b0;
    commit_c       = 1'b0;
    unique case (state_q)
      IDLE:    cfg_load_c = EF_enable;
      MEASURE: begin
        sample_en_c    = EF_enable && S_AXIS.tvalid;
        sample_first_c = (cnt_q == '0);
      end
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Counter and config shadows; counter is cleared whenever the FSM idles
  always_comb begin
    cnt_d    = cnt_q;
    log_d    = log_q;
    shift_d  = shift_q;
    update_d = commit_c;
    if (state_q != MEASURE) cnt_d = '0;
    else if (sample_en_c)   cnt_d = cnt_q + CNT_W'(1);
    if (cfg_load_c) begin
      log_d   = EF_log_count;
      shift_d = EF_shift;
    end
  end

  always_ff @(posedge SYS_aclk) begin
    if (!SYS_aresetn) begin
      cnt_q    <= '0;
      log_q    <= '0;
      shift_q  <= '0;
      update_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      log_q    <= log_d;
      shift_q  <= shift_d;
      update_q <= update_d;
    end
  end

  assign EF_update = update_q;

  for (genvar i = 0; i < int'(CHANNEL_COUNT); i++) begin : g_lane
    extremum_lane #(.W(W)) u_lane (
      .clk_i          (SYS_aclk),
      .rst_ni         (SYS_aresetn),
      .sample_en_i    (sample_en_c),
      .sample_first_i (sample_first_c),
      .commit_i       (commit_c),
      .shift_i        (shift_q),
      .sample_i       (S_AXIS.tdata[i*W +: W]),
      .lower_o        (EF_lower_treshold[i*W +: W]),
      .upper_o        (EF_upper_treshold[i*W +: W]),
      .center_o       (EF_center[i*W +: W])
    );
  end

endmodule

// File: tb/tb_extremum_tracker.sv
// Directed self-checking bench for extremum_tracker with two 16-bit lanes.
module tb_extremum_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  log_cnt;
  logic [2:0]  shift;
  logic [31:0] lower, upper, center;
  logic        upd;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int base;

  always #5 clk = ~clk;

  extremum_tracker_if #(.DATA_W(32)) s_axis ();

  extremum_tracker #(.AXIS_TDATA_WIDTH(32), .CHANNEL_COUNT(2)) dut (
    .SYS_aclk          (clk),
    .SYS_aresetn       (rst_n),
    .EF_enable         (en),
    .EF_log_count      (log_cnt),
    .EF_shift          (shift),
    .EF_lower_treshold (lower),
    .EF_upper_treshold (upper),
    .EF_center         (center),
    .EF_update         (upd),
    .S_AXIS            (s_axis)
  );

  always @(negedge clk) if (upd) upd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int l1, input int l0);
    return {16'(l1), 16'(l0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window(input logic [4:0] lc, input logic [2:0] sh);
    en      = 1'b1;
    log_cnt = lc;
    shift   = sh;
    tick();
  endtask

  task automatic feed(input logic [31:0] d);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    tick();
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    log_cnt       = '0;
    shift         = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    tick();
    tick();
    check_eq("rst_lower",  lower,  32'h7FFF7FFF);
    check_eq("rst_upper",  upper,  32'h80008000);
    check_eq("rst_center", center, 32'h00000000);
    check_eq("rst_update", 32'(upd), 32'd0);
    check_eq("tready",     32'(s_axis.tready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic window, enable dropped during COMMIT
    base = upd_cnt;
    start_window(5'd2, 3'd0);
    feed(pk(0, 5));
    feed(pk(0, -3));
    feed(pk(0, 10));
    feed(pk(0, 1));
    check_eq("basic_no_early", 32'(upd), 32'd0);
    en = 1'b0;
    tick();
    check_eq("basic_update", 32'(upd), 32'd1);
    check_eq("basic_lower",  lower,  pk(0, -3));
    check_eq("basic_upper",  upper,  pk(0, 10));
    check_eq("basic_center", center, pk(0, 3));
    tick();
    check_eq("basic_pulse_end", 32'(upd), 32'd0);
    check_eq("basic_pulse_cnt", 32'(upd_cnt - base), 32'd1);

    // Full-scale extremes with shift 1
    start_window(5'd1, 3'd1);
    feed(pk(0, -32768));
    feed(pk(0, 32767));
    en = 1'b0;
    tick();
    check_eq("ext_update", 32'(upd), 32'd1);
    check_eq("ext_center", center, pk(0, -1));
    check_eq("ext_lower",  lower,  pk(0, -16385));
    check_eq("ext_upper",  upper,  pk(0, 16383));
    tick();

    // tvalid gaps: invalid cycles carry 0x7FFF which must be ignored
    base = upd_cnt;
    start_window(5'd2, 3'd0);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = pk(-(i/2 + 1), i/2 + 1);
      end else begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 32'h7FFF7FFF;
      end
      tick();
    end
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    check_eq("gap_no_early", 32'(upd_cnt - base), 32'd0);
    en = 1'b0;
    tick();
    check_eq("gap_update", 32'(upd), 32'd1);
    check_eq("gap_lower",  lower,  pk(-4, 1));
    check_eq("gap_upper",  upper,  pk(-1, 4));
    check_eq("gap_center", center, pk(-3, 2));
    tick();

    // Abort after 3 of 4 samples, then a fresh window
    base = upd_cnt;
    start_window(5'd2, 3'd0);
    feed(pk(50, 100));
    feed(pk(60, 200));
    feed(pk(70, 300));
    en = 1'b0;
    tick();
    tick();
    tick();
    check_eq("abort_no_update", 32'(upd_cnt - base), 32'd0);
    check_eq("abort_lower",  lower,  pk(-4, 1));
    check_eq("abort_upper",  upper,  pk(-1, 4));
    check_eq("abort_center", center, pk(-3, 2));
    start_window(5'd2, 3'd0);
    feed(pk(-20, 7));
    feed(pk(20, 7));
    feed(pk(0, 7));
    check_eq("refresh_no_early", 32'(upd_cnt - base), 32'd0);
    feed(pk(0, 7));
    en = 1'b0;
    tick();
    check_eq("refresh_update", 32'(upd), 32'd1);
    check_eq("refresh_lower",  lower,  pk(-20, 7));
    check_eq("refresh_upper",  upper,  pk(20, 7));
    check_eq("refresh_center", center, pk(0, 7));
    tick();
    check_eq("refresh_pulse_cnt", 32'(upd_cnt - base), 32'd1);

    // Shift changed mid-window applies only to the following window
    start_window(5'd2, 3'd0);
    feed(pk(0, 0));
    feed(pk(0, 8));
    shift = 3'd2;
    feed(pk(0, -8));
    feed(pk(0, 4));
    en = 1'b0;
    tick();
    check_eq("cfg_cur_lower",  lower,  pk(0, -8));
    check_eq("cfg_cur_upper",  upper,  pk(0, 8));
    check_eq("cfg_cur_center", center, pk(0, 0));
    tick();
    start_window(5'd2, 3'd2);
    feed(pk(0, -8));
    feed(pk(0, 8));
    feed(pk(0, 0));
    feed(pk(0, 0));
    en = 1'b0;
    tick();
    check_eq("cfg_next_lower", lower, pk(0, -2));
    check_eq("cfg_next_upper", upper, pk(0, 2));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
